wb_master_block: RTL and testbench

// Wishbone B4 pipelined-mode bus master. Moves a block of LEN consecutive words

---
 rtl/wb_master_block.sv | 148 ++++++++++++++
 tb/tb_wb_master_block.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_block.sv
// rtl/wb_master_block.sv - Wishbone B4 pipelined block master between a local stream and a slave
module wb_master_block #(
    parameter int ADR_W   = 16,
    parameter int DAT_W   = 16,
    parameter int LEN_W   = 16,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_start_i,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic [DAT_W-1:0] wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [DAT_W-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_stall_i
);

    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic active;
    logic stb;
    logic accept;
    logic ack_v;

    assign active = (state_q != S_IDLE);
    assign stb    = (state_q == S_ISSUE) && (issued_q < len_q) &&
                    (outst_q < OUT_W'(MAX_OUT)) && (!we_q || wr_valid_i);
    assign accept = stb && !wb_stall_i;
    // Acks with nothing outstanding (stray or after an abort) are dropped here.
    assign ack_v  = active && wb_ack_i && (outst_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            adr_q    <= '0;
            len_q    <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        adr_d    = adr_q;
        len_d    = len_q;
        issued_d = issued_q;
        outst_d  = outst_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start_i) begin
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_ISSUE;
                        we_d     = cmd_we_i;
                        adr_d    = cmd_adr_i;
                        len_d    = cmd_len_i;
                        issued_d = '0;
                        outst_d  = '0;
                        tmo_d    = '0;
                    end
                end
            end
            default: begin
                if (accept) begin
                    adr_d    = adr_q + ADR_W'(1);
                    issued_d = issued_q + LEN_W'(1);
                end
                case ({accept, ack_v})
                    2'b10:   outst_d = outst_q + OUT_W'(1);
                    2'b01:   outst_d = outst_q - OUT_W'(1);
                    default: outst_d = outst_q;
                endcase
                tmo_d = (ack_v || outst_q == '0) ? '0 : tmo_q + TMO_W'(1);
                if (tmo_d == TMO_W'(TIMEOUT)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    outst_d = '0;
                end else if (state_q == S_ISSUE && issued_d == len_q) begin
                    state_d = S_DRAIN;
                end else if (state_q == S_DRAIN && outst_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    assign busy_o     = active;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign wr_ready_o = accept && we_q;
    assign rd_data_o  = wb_dat_i;
    assign rd_valid_o = ack_v && !we_q;
    assign wb_cyc_o   = active;
    assign wb_stb_o   = stb;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = (state_q == S_ISSUE && we_q) ? wr_data_i : '0;

endmodule

// File: tb/tb_wb_master_block.sv
// tb/tb_wb_master_block.sv - scoreboard bench for wb_master_block with a behavioural slave and model
module tb_wb_master_block;

    localparam int MAXO = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_adr = '0;
    logic [15:0] cmd_len = '0;
    logic        busy, done, err;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wb_cyc, wb_stb, wb_we;
    logic [15:0] wb_adr, wb_dat_o;
    logic [15:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;
    logic        wb_stall = 1'b0;

    wb_master_block #(.ADR_W(16), .DAT_W(16), .LEN_W(16), .MAX_OUT(MAXO), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_start_i(cmd_start), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .busy_o(busy), .done_o(done), .err_o(err),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_we_o(wb_we), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack), .wb_stall_i(wb_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference memory and expectation queues filled by the stimulus side
    logic [15:0] ref_mem [0:65535];
    logic [15:0] slv_mem [0:65535];
    logic [15:0] exp_adr [$];
    logic [15:0] exp_wd  [$];
    logic [15:0] exp_rd  [$];
    logic        exp_done [$];
    logic [15:0] wr_src  [$];
    logic [15:0] slv_q   [$];

    int slv_mode = 0;       // 0 pipelined, 1 stall-until-ack wrapper, 2 never acks
    bit slv_stall_en = 0;
    bit slv_ack_rand = 0;
    bit slv_force = 0;
    int wr_gap = 0;
    bit wr_gap_rand = 0;
    int out_lim = MAXO;
    int rd_seen = 0;
    int wr_pulses = 0;

    // Wishbone slave
    initial begin
        forever begin
            @(negedge clk);
            if (rst) slv_q.delete();
            else if (wb_cyc && wb_stb && !wb_stall) begin
                if (wb_we) slv_mem[wb_adr] = wb_dat_o;
                slv_q.push_back(wb_adr);
            end
            @(posedge clk); #1;
            wb_ack = 1'b0;
            wb_dat_i = 16'h0000;
            if (slv_mode == 1) wb_stall = (slv_q.size() > 0);
            else wb_stall = slv_stall_en && ($urandom_range(0, 2) == 0);
            if (slv_force) begin
                wb_ack = 1'b1;
                wb_dat_i = 16'hDEAD;
            end else if (slv_mode != 2 && slv_q.size() > 0 &&
                         (!slv_ack_rand || $urandom_range(0, 3) != 0)) begin
                wb_ack = 1'b1;
                wb_dat_i = slv_mem[slv_q.pop_front()];
            end
        end
    end

    // Write stream source
    initial begin
        bit cap;
        bit flush;
        int gap_cnt;
        gap_cnt = 0;
        forever begin
            @(negedge clk);
            cap = wr_valid && wr_ready;
            flush = rst;
            @(posedge clk); #1;
            if (flush) begin
                wr_src.delete();
                gap_cnt = 0;
            end else if (cap) begin
                void'(wr_src.pop_front());
                gap_cnt = wr_gap_rand ? $urandom_range(0, 2) : wr_gap;
            end
            if (gap_cnt > 0) begin
                gap_cnt--;
                wr_valid = 1'b0;
            end else if (wr_src.size() > 0) begin
                wr_valid = 1'b1;
                wr_data = wr_src[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    // Monitor: transaction-level model of the block, checked every cycle
    bit          m_active = 0;
    bit          m_we = 0;
    bit          m_due = 0;
    int          m_len = 0, m_issued = 0, m_out = 0, m_tmo = 0;
    bit          prev_stalled = 0;
    logic [15:0] prev_adr = '0;

    initial begin
        bit acc, ackv, exp_stb;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_adr.delete(); exp_wd.delete(); exp_rd.delete(); exp_done.delete();
                m_active = 0; m_due = 0; m_out = 0; prev_stalled = 0;
                continue;
            end
            acc  = wb_stb && !wb_stall;
            ackv = wb_ack && m_active && (m_out > 0);

            if (done || m_due) begin
                chk("done_timing", done, m_due);
                if (done) begin
                    if (exp_done.size() == 0) chk("done_extra", 1, 0);
                    else chk("done_err", err, exp_done.pop_front());
                end
            end
            m_due = 0;
            chk("busy", busy, m_active);
            chk("cyc", wb_cyc, m_active);
            if (m_active || wb_stb) begin
                exp_stb = m_active && (m_issued < m_len) && (m_out < MAXO) && (!m_we || wr_valid);
                chk("stb", wb_stb, exp_stb);
            end
            if (m_active) chk("we_held", wb_we, m_we);
            if (prev_stalled) chk("adr_hold", wb_adr, prev_adr);
            prev_stalled = wb_stb && wb_stall;
            prev_adr = wb_adr;

            if (acc) begin
                if (exp_adr.size() == 0) chk("adr_extra", 1, 0);
                else chk("adr", wb_adr, exp_adr.pop_front());
                if (m_we) begin
                    if (exp_wd.size() == 0) chk("wdat_extra", 1, 0);
                    else chk("wdat", wb_dat_o, exp_wd.pop_front());
                end
            end
            if (wr_ready || (acc && m_we)) chk("wr_ready", wr_ready, acc && m_we);
            if (wr_ready) wr_pulses++;
            if (wb_ack || rd_valid) chk("rd_valid", rd_valid, ackv && !m_we);
            if (rd_valid && ackv && !m_we) begin
                rd_seen++;
                if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
                else chk("rd_data", rd_data, exp_rd.pop_front());
            end

            if (m_active) begin
                if (ackv || m_out == 0) m_tmo = 0;
                else m_tmo++;
                m_issued += int'(acc);
                m_out = m_out + int'(acc) - int'(ackv);
                if (acc) chk("outstanding_max", m_out <= out_lim, 1);
                if (m_tmo == TMO) begin
                    m_active = 0; m_due = 1; m_out = 0;
                end else if (m_issued == m_len && m_out == 0) begin
                    m_active = 0; m_due = 1;
                end
            end else if (cmd_start) begin
                if (cmd_len == 0) m_due = 1;
                else begin
                    m_active = 1; m_we = cmd_we; m_len = int'(cmd_len);
                    m_issued = 0; m_out = 0; m_tmo = 0;
                end
            end
        end
    end

    task automatic start_cmd(input bit we, input logic [15:0] adr, input int len, input bit abort);
        logic [15:0] a, d;
        for (int i = 0; i < len; i++) begin
            a = 16'(adr + 16'(i));
            exp_adr.push_back(a);
            if (we) begin
                d = 16'($urandom);
                wr_src.push_back(d);
                exp_wd.push_back(d);
                ref_mem[a] = d;
            end else if (!abort) begin
                exp_rd.push_back(ref_mem[a]);
            end
        end
        exp_done.push_back(abort);
        @(posedge clk); #1;
        cmd_we = we; cmd_adr = adr; cmd_len = 16'(len); cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({name, "_timeout"}, 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input string name, input bit we, input logic [15:0] adr, input int len, input bit abort);
        start_cmd(we, adr, len, abort);
        wait_done(name);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int p0, r0, n;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 16'(i) ^ 16'hA5A5;
            slv_mem[i] = 16'(i) ^ 16'hA5A5;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {wb_cyc, wb_stb, wb_we, busy, done, err, wr_ready, rd_valid}, 0);
        chk("reset_adr", wb_adr, 0);
        chk("reset_dat", wb_dat_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // pipelined read, no stalls
        run_cmd("t1_read", 0, 16'h0010, 4, 0);

        // write with two idle cycles between stream words, then read back
        wr_gap = 2;
        p0 = wr_pulses;
        run_cmd("t2_write", 1, 16'h0100, 3, 0);
        chk("t2_wr_pulses", wr_pulses - p0, 3);
        wr_gap = 0;
        run_cmd("t2_readback", 0, 16'h0100, 3, 0);

        // standard slave behind a stall-until-ack wrapper
        slv_mode = 1; out_lim = 1;
        r0 = rd_seen;
        run_cmd("t3_read", 0, 16'h0200, 8, 0);
        chk("t3_acks", rd_seen - r0, 8);
        slv_mode = 0; out_lim = MAXO;

        // address wrap under random stall and ack delay, then zero length
        slv_stall_en = 1; slv_ack_rand = 1;
        run_cmd("t4_wrap_rd", 0, 16'hFFFE, 4, 0);
        run_cmd("t4_wrap_wr", 1, 16'hFFFE, 4, 0);
        run_cmd("t4_wrap_rb", 0, 16'hFFFE, 4, 0);
        run_cmd("t4_len0", 0, 16'h1234, 0, 0);

        // randomized blocks
        wr_gap_rand = 1;
        for (int k = 0; k < 24; k++) begin
            logic [15:0] ra;
            ra = (k % 3 == 0) ? 16'($urandom) : 16'(16'h0500 + 16'($urandom_range(0, 31)));
            run_cmd("rand", 1'($urandom_range(0, 1)), ra, $urandom_range(0, 12), 0);
        end
        wr_gap_rand = 0; slv_stall_en = 0; slv_ack_rand = 0;

        // slave never acks: abort after TMO idle cycles with accesses outstanding
        slv_mode = 2;
        run_cmd("t5_timeout", 0, 16'h0300, 10, 1);
        chk("t5_issued", exp_adr.size(), 10 - MAXO);
        exp_adr.delete();
        slv_force = 1;
        repeat (3) @(posedge clk);
        #1 slv_force = 0;
        slv_q.delete();
        slv_mode = 0;
        repeat (2) @(posedge clk);

        // reset in the middle of a block
        slv_ack_rand = 1;
        r0 = rd_seen;
        start_cmd(0, 16'h0600, 6, 0);
        n = 0;
        while (rd_seen - r0 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_partial", (rd_seen - r0 >= 2) && (rd_seen - r0 < 6), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #2;
        chk("t6_reset_ctrl", {wb_cyc, wb_stb, wb_we, busy, done, err, wr_ready, rd_valid}, 0);
        chk("t6_reset_adr", wb_adr, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        slv_ack_rand = 0;
        #1;
        run_cmd("t6_after", 0, 16'h0700, 3, 0);

        repeat (3) @(posedge clk);
        chk("end_adr_q", exp_adr.size(), 0);
        chk("end_rd_q", exp_rd.size(), 0);
        chk("end_wd_q", exp_wd.size(), 0);
        chk("end_done_q", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
